// File: rtl/rst_r_drain_seq_if.sv
// Bundles the write-domain marker/flag, the read-side pointer status, and the
// reset/ack results exchanged with the read-domain drain sequencer.
// master: the environment (write marker source + read pointer logic); slave: the sequencer.
// Ports: flg_async/marker_gray_async (async in), rptr/rd_en/empty (clk_r in),
//        rst_r_gen/ack/drain_active/drain_cnt/err (clk_r out).
interface rst_r_drain_seq_if #(
   parameter int AW = 10
);
   logic          flg_async;
   logic [AW:0]   marker_gray_async;
   logic [AW-1:0] rptr;
   logic          rd_en;
   logic          empty;
   logic          rst_r_gen;
   logic          ack;
   logic          drain_active;
   logic [AW:0]   drain_cnt;
   logic          err;

   modport master (
      output flg_async, marker_gray_async, rptr, rd_en, empty,
      input  rst_r_gen, ack, drain_active, drain_cnt, err
   );

   modport slave (
      input  flg_async, marker_gray_async, rptr, rd_en, empty,
      output rst_r_gen, ack, drain_active, drain_cnt, err
   );
endinterface

// File: rtl/rst_r_drain_seq.sv
// Read-domain sequencer: drains the FIFO up to the write-side marker, then pulses rst_r_gen low.
// Latency: flag to CAPTURE 3 edges, stable marker to DRAIN +1, DRAIN exit to rst_r_gen low 1 edge.
// Backpressure: none; the reader paces the drain, an empty FIFO for TIMEOUT cycles abandons it.
// Ports: clk_r/rst_r (sync active-high reset); bus.slave carries the async flag/marker,
//        the read pointer status, and the registered outputs rst_r_gen (active-low),
//        ack, drain_active, drain_cnt (saturating) and err (sticky timeout).
module rst_r_drain_seq #(
   parameter int depth      = 1024,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 2048
) (
   input  logic             clk_r,
   input  logic             rst_r,
   rst_r_drain_seq_if.slave bus
);
   localparam int AW  = $clog2(depth);
   localparam int ECW = $clog2(TIMEOUT + 1);
   localparam int RCW = $clog2(RST_CYCLES + 1);

   localparam logic [ECW-1:0] EC_LAST = ECW'(TIMEOUT - 1);
   localparam logic [ECW-1:0] EC_ONE  = ECW'(1);
   localparam logic [RCW-1:0] RC_LOAD = RCW'(RST_CYCLES);
   localparam logic [RCW-1:0] RC_ONE  = RCW'(1);
   localparam logic [AW:0]    DC_ONE  = (AW + 1)'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DRAIN,
      ST_RESET,
      ST_ACK
   } state_t;

   state_t         state_q;
   logic           flg_s1_q, flg_s_q;
   logic [AW:0]    mk_s1_q, mk_s_q, mk_prev_q;
   logic [AW-1:0]  mk_l_q;
   logic [AW:0]    drain_cnt_q;
   logic [ECW-1:0] empty_cnt_q;
   logic [RCW-1:0] rst_cnt_q;
   logic           rst_r_gen_q, ack_q, drain_active_q, err_q;
   logic [AW-1:0]  mk_bin;

   // Marker MSB is always zero on the write side; it still seeds the XOR
   // chain so only the AW pointer bits come out.
   function automatic logic [AW-1:0] gray2bin(input logic [AW:0] g);
      logic [AW-1:0] b;
      logic          acc;
      acc = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         acc  = acc ^ g[i];
         b[i] = acc;
      end
      return b;
   endfunction

   assign mk_bin = gray2bin(mk_s_q);

   always_ff @(posedge clk_r) begin
      if (rst_r) begin
         state_q        <= ST_IDLE;
         flg_s1_q       <= 1'b0;
         flg_s_q        <= 1'b0;
         mk_s1_q        <= '0;
         mk_s_q         <= '0;
         mk_prev_q      <= '0;
         mk_l_q         <= '0;
         drain_cnt_q    <= '0;
         empty_cnt_q    <= '0;
         rst_cnt_q      <= '0;
         rst_r_gen_q    <= 1'b1;
         ack_q          <= 1'b0;
         drain_active_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         flg_s1_q  <= bus.flg_async;
         flg_s_q   <= flg_s1_q;
         mk_s1_q   <= bus.marker_gray_async;
         mk_s_q    <= mk_s1_q;
         mk_prev_q <= mk_s_q;

         case (state_q)
            ST_IDLE: begin
               if (flg_s_q) begin
                  state_q     <= ST_CAPTURE;
                  drain_cnt_q <= '0;
               end
            end

            ST_CAPTURE: begin
               if (!flg_s_q) begin
                  state_q <= ST_IDLE;
               end else if (mk_s_q == mk_prev_q) begin
                  // Two equal consecutive samples: the multi-bit word has settled.
                  mk_l_q         <= mk_bin;
                  empty_cnt_q    <= '0;
                  state_q        <= ST_DRAIN;
                  drain_active_q <= 1'b1;
               end
            end

            ST_DRAIN: begin
               if (bus.rd_en && !bus.empty && (drain_cnt_q != '1)) begin
                  drain_cnt_q <= drain_cnt_q + DC_ONE;
               end
               if (bus.empty) begin
                  empty_cnt_q <= empty_cnt_q + EC_ONE;
               end else begin
                  empty_cnt_q <= '0;
               end

               if (!flg_s_q) begin
                  state_q        <= ST_IDLE;
                  drain_active_q <= 1'b0;
               end else if (bus.rptr == mk_l_q) begin
                  // Equality only, so pointer wrap needs no special casing.
                  state_q        <= ST_RESET;
                  drain_active_q <= 1'b0;
                  rst_r_gen_q    <= 1'b0;
                  rst_cnt_q      <= RC_LOAD;
               end else if (bus.empty && (empty_cnt_q == EC_LAST)) begin
                  // This empty cycle is the TIMEOUT-th in a row.
                  err_q          <= 1'b1;
                  state_q        <= ST_RESET;
                  drain_active_q <= 1'b0;
                  rst_r_gen_q    <= 1'b0;
                  rst_cnt_q      <= RC_LOAD;
               end
            end

            ST_RESET: begin
               if (rst_cnt_q == RC_ONE) begin
                  state_q     <= ST_ACK;
                  rst_r_gen_q <= 1'b1;
                  ack_q       <= 1'b1;
               end else begin
                  rst_cnt_q <= rst_cnt_q - RC_ONE;
               end
            end

            ST_ACK: begin
               if (!flg_s_q) begin
                  state_q <= ST_IDLE;
                  ack_q   <= 1'b0;
               end
            end

            default: begin
               state_q        <= ST_IDLE;
               rst_r_gen_q    <= 1'b1;
               ack_q          <= 1'b0;
               drain_active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_r_gen    = rst_r_gen_q;
   assign bus.ack          = ack_q;
   assign bus.drain_active = drain_active_q;
   assign bus.drain_cnt    = drain_cnt_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_rst_r_drain_seq.sv
// Bench for rst_r_drain_seq: episodes of flag/marker/reader activity are issued,
// the expected episode outcome is queued, and a negedge monitor rebuilds each
// observed episode from the outputs and compares it against the queue head.
module tb_rst_r_drain_seq;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int RSTC  = 4;
   localparam int TO    = 64;
   localparam int PLEN  = 300;

   logic clk_r = 1'b0;
   logic rst_r = 1'b1;

   rst_r_drain_seq_if #(.AW(AW)) bus ();

   rst_r_drain_seq #(
      .depth      (DEPTH),
      .RST_CYCLES (RSTC),
      .TIMEOUT    (TO)
   ) dut (
      .clk_r (clk_r),
      .rst_r (rst_r),
      .bus   (bus)
   );

   always #5 clk_r = ~clk_r;

   typedef struct {
      int lat_in;
      int dlen;
      int dcnt;
      int aborted;
      int plen;
      int err;
      int ack;
      int lat_out;
   } ep_t;

   ep_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;
   bit  plan_rd[PLEN];
   bit  plan_em[PLEN];
   int  err_sticky  = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic finish_ep(input ep_t a);
      ep_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_episode: got drain of %0d cycles, expected none", a.dlen);
      end else begin
         e = exp_q.pop_front();
         check("lat_in",    a.lat_in,  e.lat_in);
         check("drain_len", a.dlen,    e.dlen);
         check("drain_cnt", a.dcnt,    e.dcnt);
         check("aborted",   a.aborted, e.aborted);
         check("pulse_len", a.plen,    e.plen);
         check("err",       a.err,     e.err);
         check("ack",       a.ack,     e.ack);
         check("lat_out",   a.lat_out, e.lat_out);
      end
   endtask

   // ---------------- monitor ----------------
   int  cyc      = 0;
   int  arm_cyc  = 0;
   int  fall_cyc = 0;
   bit  prev_flg = 1'b0;
   bit  prev_rst = 1'b1;
   int  mstate   = 0;
   ep_t cur;

   always @(negedge clk_r) begin
      cyc++;
      if (bus.flg_async && !prev_flg) arm_cyc = cyc;
      if (!rst_r && prev_rst)         arm_cyc = cyc;
      if (!bus.flg_async && prev_flg) fall_cyc = cyc;
      prev_flg = bus.flg_async;
      prev_rst = rst_r;
      case (mstate)
         0: begin
            if (bus.drain_active === 1'b1) begin
               cur.lat_in  = cyc - arm_cyc;
               cur.dlen    = 1;
               cur.dcnt    = -1;
               cur.aborted = -1;
               cur.plen    = -1;
               cur.err     = -1;
               cur.ack     = -1;
               cur.lat_out = -1;
               mstate      = 1;
            end
         end
         1: begin
            if (bus.drain_active) begin
               cur.dlen++;
            end else begin
               cur.dcnt = int'(bus.drain_cnt);
               if (!bus.rst_r_gen) begin
                  cur.aborted = 0;
                  cur.plen    = 1;
                  mstate      = 2;
               end else begin
                  cur.aborted = 1;
                  finish_ep(cur);
                  mstate = 0;
               end
            end
         end
         2: begin
            if (!bus.rst_r_gen) begin
               cur.plen++;
            end else begin
               cur.err = int'(bus.err);
               cur.ack = int'(bus.ack);
               if (bus.ack) begin
                  mstate = 3;
               end else begin
                  finish_ep(cur);
                  mstate = 0;
               end
            end
         end
         default: begin
            if (!bus.ack) begin
               cur.lat_out = cyc - fall_cyc;
               finish_ep(cur);
               mstate = 0;
            end
         end
      endcase
   end

   // ---------------- reference model ----------------
   function automatic bit prd(input int k);
      return (k < PLEN) ? plan_rd[k] : 1'b0;
   endfunction

   function automatic bit pem(input int k);
      return (k < PLEN) ? plan_em[k] : 1'b1;
   endfunction

   // Walks the reader plan one drain cycle at a time: abort wins, then reaching
   // the marker, then TIMEOUT consecutive empty cycles.
   function automatic ep_t model(input int mk, input int p0, input int ka, output bit timed);
      ep_t e;
      int  ptr  = p0;
      int  cnt  = 0;
      int  ecnt = 0;
      int  k    = 0;
      bit  done = 1'b0;
      bit  r, em;
      timed     = 1'b0;
      e.aborted = 0;
      while (!done) begin
         r  = prd(k);
         em = pem(k);
         if (r && !em && cnt < 31) cnt++;
         if (k == ka) begin
            e.aborted = 1;
            done      = 1'b1;
         end else if (ptr == mk) begin
            done = 1'b1;
         end else begin
            ecnt = em ? ecnt + 1 : 0;
            if (ecnt == TO) begin
               timed = 1'b1;
               done  = 1'b1;
            end
         end
         if (!done) begin
            if (r && !em) ptr = (ptr + 1) % DEPTH;
            k++;
         end
      end
      e.lat_in  = 4;
      e.dlen    = k + 1;
      e.dcnt    = cnt;
      e.plen    = -1;
      e.err     = -1;
      e.ack     = -1;
      e.lat_out = -1;
      return e;
   endfunction

   // ---------------- stimulus ----------------
   function automatic logic [AW:0] to_gray(input int b);
      logic [AW:0] v;
      v = (AW + 1)'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic step();
      @(posedge clk_r);
      #1;
      if (bus.rd_en && !bus.empty) bus.rptr = bus.rptr + 4'd1;
   endtask

   task automatic clear_plan(input bit rd, input bit em);
      for (int i = 0; i < PLEN; i++) begin
         plan_rd[i] = rd;
         plan_em[i] = em;
      end
   endtask

   task automatic random_plan();
      for (int i = 0; i < PLEN; i++) begin
         plan_rd[i] = ($urandom_range(1, 0) == 1);
         plan_em[i] = ($urandom_range(2, 0) == 0);
      end
   endtask

   task automatic reset_check();
      step();
      rst_r = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.flg_async         = 1'($urandom_range(1, 0));
         bus.marker_gray_async = 5'($urandom_range(31, 0));
         bus.rd_en             = 1'($urandom_range(1, 0));
         bus.empty             = 1'($urandom_range(1, 0));
         step();
      end
      @(negedge clk_r);
      check("rst_rst_r_gen",    int'(bus.rst_r_gen),    1);
      check("rst_ack",          int'(bus.ack),          0);
      check("rst_drain_active", int'(bus.drain_active), 0);
      check("rst_drain_cnt",    int'(bus.drain_cnt),    0);
      check("rst_err",          int'(bus.err),          0);
      bus.flg_async = 1'b0;
      bus.rd_en     = 1'b0;
      bus.empty     = 1'b0;
      step();
      rst_r      = 1'b0;
      err_sticky = 0;
      repeat (3) step();
   endtask

   // ka_req: -1 no abort, -2 random abort point, >=0 abort in that drain cycle.
   task automatic run_episode(input int mk, input int p0, input int ka_req, input bit midrst);
      ep_t e;
      ep_t e2;
      bit  timed;
      int  ka;
      int  n;
      e  = model(mk, p0, -1, timed);
      ka = -1;
      if (ka_req == -2)                    ka = int'($urandom_range(e.dlen - 1, 0));
      else if (ka_req >= 0 && ka_req < e.dlen) ka = ka_req;
      if (ka >= 0) e = model(mk, p0, ka, timed);
      if (e.aborted == 0) begin
         if (timed) err_sticky = 1;
         e.plen    = midrst ? 2 : RSTC;
         e.err     = midrst ? 0 : err_sticky;
         e.ack     = midrst ? 0 : 1;
         e.lat_out = midrst ? -1 : 3;
      end
      exp_q.push_back(e);
      if (midrst) begin
         e2.lat_in  = 4;
         e2.dlen    = 1;
         e2.dcnt    = 0;
         e2.aborted = 0;
         e2.plen    = RSTC;
         e2.err     = 0;
         e2.ack     = 1;
         e2.lat_out = 3;
         exp_q.push_back(e2);
      end

      step();
      bus.marker_gray_async = to_gray(mk);
      bus.rptr              = 4'(p0);
      bus.flg_async         = 1'b1;
      bus.rd_en             = 1'b0;
      bus.empty             = 1'b0;
      for (int i = 1; i < 4 + e.dlen; i++) begin
         step();
         if (ka >= 0 && i == ka + 2) bus.flg_async = 1'b0;
         if (i >= 4) begin
            bus.rd_en = prd(i - 4);
            bus.empty = pem(i - 4);
         end
      end
      step();
      bus.rd_en = 1'b0;
      bus.empty = 1'($urandom_range(1, 0));

      if (ka >= 0) begin
         repeat (3) step();
         return;
      end

      if (midrst) begin
         step();
         rst_r = 1'b1;
         step();
         step();
         rst_r      = 1'b0;
         err_sticky = 0;
      end

      n = 0;
      while (bus.ack !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      if (n >= 400) check("ack_rise_wait", int'(bus.ack), 1);
      repeat ($urandom_range(4, 0)) step();
      bus.flg_async = 1'b0;
      n = 0;
      while (bus.ack !== 1'b0 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check("ack_fall_wait", int'(bus.ack), 0);
      repeat (3) step();
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion, expected finish within budget");
      $fatal(1);
   end

   initial begin
      bus.flg_async         = 1'b0;
      bus.marker_gray_async = '0;
      bus.rptr              = '0;
      bus.rd_en             = 1'b0;
      bus.empty             = 1'b0;
      rst_r                 = 1'b1;

      reset_check();

      // Normal drain: marker 5 (gray 00111), reader from 2 reads three entries.
      clear_plan(1'b0, 1'b0);
      plan_rd[0] = 1'b1;
      plan_rd[1] = 1'b1;
      plan_rd[2] = 1'b1;
      run_episode(5, 2, -1, 1'b0);

      // Pointer already at the marker.
      clear_plan(1'b0, 1'b0);
      run_episode(9, 9, -1, 1'b0);

      // Drain timeout with the FIFO held empty, then err must stay set.
      clear_plan(1'b0, 1'b1);
      run_episode(7, 3, -1, 1'b0);
      clear_plan(1'b0, 1'b0);
      run_episode(9, 9, -1, 1'b0);
      reset_check();

      // Flag dropped mid-drain.
      clear_plan(1'b1, 1'b0);
      run_episode(12, 4, 3, 1'b0);

      // Reset arriving in the second cycle of the reset pulse.
      clear_plan(1'b0, 1'b0);
      run_episode(6, 6, -1, 1'b1);

      for (int t = 0; t < 24; t++) begin
         random_plan();
         run_episode(int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(DEPTH - 1, 0)),
                     ($urandom_range(3, 0) == 0) ? -2 : -1, 1'b0);
         if ($urandom_range(4, 0) == 0) reset_check();
      end

      repeat (10) step();
      check("scoreboard_drained", exp_q.size(), 0);
      check("monitor_idle", mstate, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
